// File: rtl/formacao_inimigos.sv
// Enemy formation controller: block march, alive mask, bullet collision, score and end-of-game flags.
// The enemy-shot request/ack logic is built only when FORMACAO_TIRO_EN is defined.
module formacao_inimigos #(
  parameter int N_COLS       = 8,
  parameter int N_ROWS       = 3,
  parameter int LARG         = 30,
  parameter int ALT          = 20,
  parameter int ESP_X        = 40,
  parameter int ESP_Y        = 30,
  parameter int PASSO_X      = 4,
  parameter int PASSO_Y      = 10,
  parameter int XI           = 20,
  parameter int YI           = 40,
  parameter int X_MAX        = 639,
  parameter int Y_LIMITE     = 400,
  parameter int TICK_DIV     = 1_000_000,
  parameter int TIRO_PERIODO = 8,
  parameter int PONTOS_W     = 8
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       pausa,
  input  logic                       reiniciarJogo,
  input  logic [9:0]                 bola_x,
  input  logic [9:0]                 bola_y,
  input  logic                       bola_ativa,
  output logic [9:0]                 x_base,
  output logic [9:0]                 y_base,
  output logic [N_COLS*N_ROWS-1:0]   vivos,
  output logic                       acerto,
  output logic [PONTOS_W-1:0]        pontos,
  output logic                       todos_mortos,
  output logic                       invadiu,
  output logic                       tiro_req,
  output logic [9:0]                 tiro_x,
  output logic [9:0]                 tiro_y,
  input  logic                       tiro_ack
);

  localparam int N     = N_COLS * N_ROWS;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_FIM   = DIV_W'(TICK_DIV - 1);
  localparam logic [10:0]      EXT_DIR   = 11'((N_COLS - 1) * ESP_X + LARG - 1 + PASSO_X);
  localparam logic [10:0]      ALT_GRADE = 11'((N_ROWS - 1) * ESP_Y + ALT);

  typedef enum logic [1:0] {MARCHA, DESCE, VITORIA, INVASAO} estado_t;

  estado_t          estado, estado_nxt;
  logic             direita, dir_nxt;
  logic [9:0]       x_nxt, y_nxt;
  logic [N-1:0]     vivos_nxt;
  logic [N-1:0]     dentro;
  logic [DIV_W-1:0] div_cnt;
  logic             tick, ativo, hit;

  assign tick         = !pausa && (div_cnt == DIV_FIM);
  assign ativo        = (estado == MARCHA) || (estado == DESCE);
  assign todos_mortos = (estado == VITORIA);
  assign invadiu      = (estado == INVASAO);

  // Box test per enemy, 11-bit so the right/bottom edges never wrap.
  for (genvar r = 0; r < N_ROWS; r++) begin : g_linha
    for (genvar c = 0; c < N_COLS; c++) begin : g_coluna
      logic [10:0] ex, ey;
      assign ex = {1'b0, x_base} + 11'(c * ESP_X);
      assign ey = {1'b0, y_base} + 11'(r * ESP_Y);
      assign dentro[r*N_COLS+c] = ({1'b0, bola_x} >= ex) && ({1'b0, bola_x} < ex + 11'(LARG)) &&
                                  ({1'b0, bola_y} >= ey) && ({1'b0, bola_y} < ey + 11'(ALT));
    end
  end

  // Lowest alive index inside the box is the single kill of this cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    hit       = 1'b0;
    vivos_nxt = vivos;
    for (int i = 0; i < N; i++) begin
      if (!hit && ativo && bola_ativa && vivos[i] && dentro[i]) begin
        hit          = 1'b1;
        vivos_nxt[i] = 1'b0;
      end
    end
  end

  always_comb begin
    estado_nxt = estado;
    x_nxt      = x_base;
    y_nxt      = y_base;
    dir_nxt    = direita;
    case (estado)
      MARCHA: if (tick) begin
        if (direita) begin
          if ({1'b0, x_base} + EXT_DIR <= 11'(X_MAX)) x_nxt = x_base + 10'(PASSO_X);
          else                                        estado_nxt = DESCE;
        end else if (x_base >= 10'(PASSO_X)) begin
          x_nxt = x_base - 10'(PASSO_X);
        end else begin
          estado_nxt = DESCE;
        end
      end
      DESCE: if (tick) begin
        y_nxt      = y_base + 10'(PASSO_Y);
        dir_nxt    = !direita;
        estado_nxt = ({1'b0, y_base} + 11'(PASSO_Y) + ALT_GRADE >= 11'(Y_LIMITE)) ? INVASAO : MARCHA;
      end
      default: ;
    endcase
    // Victory wins over an invasion detected on the same edge.
    if (ativo && (vivos_nxt == '0)) estado_nxt = VITORIA;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    // NOTE: sequential state is assigned with <= only, so every register sees pre-edge values.
    if (reset) begin
      estado  <= MARCHA;
      x_base  <= 10'(XI);
      y_base  <= 10'(YI);
      direita <= 1'b1;
      vivos   <= '1;
      acerto  <= 1'b0;
      pontos  <= '0;
      div_cnt <= '0;
    end else if (reiniciarJogo) begin
      estado  <= MARCHA;
      x_base  <= 10'(XI);
      y_base  <= 10'(YI);
      direita <= 1'b1;
      vivos   <= '1;
      acerto  <= 1'b0;
      pontos  <= '0;
      div_cnt <= '0;
    end else if (pausa) begin
      acerto  <= 1'b0;
    end else begin
      estado  <= estado_nxt;
      x_base  <= x_nxt;
      y_base  <= y_nxt;
      direita <= dir_nxt;
      vivos   <= vivos_nxt;
      acerto  <= hit;
      if (hit && (pontos != '1)) pontos <= pontos + 1'b1;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

`ifdef FORMACAO_TIRO_EN
  localparam int PER_W = (TIRO_PERIODO > 1) ? $clog2(TIRO_PERIODO) : 1;
  localparam int PTR_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam logic [PER_W-1:0] PER_FIM = PER_W'(TIRO_PERIODO - 1);
  localparam logic [PTR_W-1:0] PTR_FIM = PTR_W'(N_COLS - 1);

  logic [PER_W-1:0] per_cnt;
  logic [PTR_W-1:0] ptr;
  logic             col_viva, tentativa;
  logic [9:0]       alvo_x, alvo_y;

  assign tentativa = tick && ativo && (per_cnt == PER_FIM);

  // Shot origin uses the post-edge position and mask; the last matching row is the lowest on screen.
  always_comb begin
    col_viva = 1'b0;
    alvo_x   = '0;
    alvo_y   = '0;
    for (int c = 0; c < N_COLS; c++) begin
      for (int r = 0; r < N_ROWS; r++) begin
        if ((c == int'(ptr)) && vivos_nxt[r*N_COLS+c]) begin
          col_viva = 1'b1;
          alvo_x   = x_nxt + 10'(c * ESP_X + LARG / 2);
          alvo_y   = y_nxt + 10'(r * ESP_Y + ALT);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      per_cnt  <= '0;
      ptr      <= '0;
      tiro_req <= 1'b0;
      tiro_x   <= '0;
      tiro_y   <= '0;
    end else if (reiniciarJogo) begin
      per_cnt  <= '0;
      ptr      <= '0;
      tiro_req <= 1'b0;
      tiro_x   <= '0;
      tiro_y   <= '0;
    end else if (!pausa) begin
      if (tick && ativo) per_cnt <= (per_cnt == PER_FIM) ? '0 : per_cnt + 1'b1;
      if (tiro_req) begin
        if (tiro_ack) tiro_req <= 1'b0;
      end else if (tentativa) begin
        ptr <= (ptr == PTR_FIM) ? '0 : ptr + 1'b1;
        if (col_viva) begin
          tiro_req <= 1'b1;
          tiro_x   <= alvo_x;
          tiro_y   <= alvo_y;
        end
      end
    end
  end
`else
  logic unused_ack;
  assign unused_ack = tiro_ack ^ (TIRO_PERIODO == 0);
  assign tiro_req   = 1'b0;
  assign tiro_x     = '0;
  assign tiro_y     = '0;
`endif

endmodule

// File: tb/tb_formacao_inimigos.sv
// Scoreboard bench for formacao_inimigos: a behavioural game model predicts every cycle's outputs,
// a monitor compares them, and directed phases cover reset, hits, edges, victory, invasion, shots and pause.
module tb_formacao_inimigos;

  localparam int NC = 2, NR = 2, N = NC * NR;
  localparam int TD = 4, TP = 2;
  localparam int LARG = 30, ALT = 20, ESP_X = 40, ESP_Y = 30;
  localparam int PX = 4, PY = 10, XI = 20, YI = 40, XMAX = 639, YLIM = 400;
`ifdef FORMACAO_TIRO_EN
  localparam bit SHOT_EN = 1'b1;
`else
  localparam bit SHOT_EN = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic reset, pausa, reiniciarJogo, bola_ativa, tiro_ack;
  logic [9:0] bola_x, bola_y, x_base, y_base, tiro_x, tiro_y;
  logic [N-1:0] vivos;
  logic [7:0] pontos;
  logic acerto, todos_mortos, invadiu, tiro_req;

  formacao_inimigos #(
    .N_COLS(NC), .N_ROWS(NR), .LARG(LARG), .ALT(ALT), .ESP_X(ESP_X), .ESP_Y(ESP_Y),
    .PASSO_X(PX), .PASSO_Y(PY), .XI(XI), .YI(YI), .X_MAX(XMAX), .Y_LIMITE(YLIM),
    .TICK_DIV(TD), .TIRO_PERIODO(TP), .PONTOS_W(8)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciarJogo),
    .bola_x(bola_x), .bola_y(bola_y), .bola_ativa(bola_ativa),
    .x_base(x_base), .y_base(y_base), .vivos(vivos), .acerto(acerto), .pontos(pontos),
    .todos_mortos(todos_mortos), .invadiu(invadiu),
    .tiro_req(tiro_req), .tiro_x(tiro_x), .tiro_y(tiro_y), .tiro_ack(tiro_ack)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int x, y; logic [N-1:0] vivos; bit acerto; int pontos; bit win, inv, req; int tx, ty;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0, errors = 0;
  bit    mon_en = 1'b0;

  // Game model state.
  int m_x, m_y, m_score, m_div, m_tcnt, m_ptr, m_tx, m_ty;
  bit m_right, m_desc, m_win, m_inv, m_req, m_acerto;
  bit m_alive[N];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [N-1:0] pack_alive();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_alive[i];
    return v;
  endfunction

  function automatic int alive_count();
    int n = 0;
    for (int i = 0; i < N; i++) n += int'(m_alive[i]);
    return n;
  endfunction

  function automatic bit in_box(int i);
    int ex = m_x + (i % NC) * ESP_X;
    int ey = m_y + (i / NC) * ESP_Y;
    int bx = int'(bola_x);
    int by = int'(bola_y);
    return (bx >= ex) && (bx < ex + LARG) && (by >= ey) && (by < ey + ALT);
  endfunction

  task automatic model_reset();
    m_x = XI; m_y = YI; m_score = 0; m_div = 0; m_tcnt = 0; m_ptr = 0; m_tx = 0; m_ty = 0;
    m_right = 1; m_desc = 0; m_win = 0; m_inv = 0; m_req = 0; m_acerto = 0;
    for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
  endtask

  // One clock edge of the game, applied to the inputs currently driven.
  task automatic model_step();
    bit tick, term, was_req;
    if (reiniciarJogo) begin model_reset(); return; end
    if (pausa) begin m_acerto = 0; return; end
    tick  = (m_div == TD - 1);
    m_div = tick ? 0 : m_div + 1;
    term  = m_win || m_inv;
    m_acerto = 0;
    if (!term && bola_ativa) begin
      for (int i = 0; i < N; i++) begin
        if (m_alive[i] && in_box(i)) begin
          m_alive[i] = 0; m_acerto = 1;
          if (m_score < 255) m_score++;
          break;
        end
      end
    end
    if (tick && !term) begin
      if (m_desc) begin
        m_y += PY; m_right = !m_right; m_desc = 0;
        if (m_y + (NR - 1) * ESP_Y + ALT >= YLIM) m_inv = 1;
      end else if (m_right) begin
        if (m_x + (NC - 1) * ESP_X + LARG - 1 + PX <= XMAX) m_x += PX;
        else m_desc = 1;
      end else begin
        if (m_x >= PX) m_x -= PX;
        else m_desc = 1;
      end
    end
    if (!term && alive_count() == 0) begin m_win = 1; m_inv = 0; end
    if (SHOT_EN) begin
      was_req = m_req;
      if (m_req && tiro_ack) m_req = 0;
      if (tick && !term) begin
        if (m_tcnt == TP - 1) begin
          m_tcnt = 0;
          if (!was_req) begin
            for (int r = NR - 1; r >= 0; r--) begin
              if (m_alive[r * NC + m_ptr]) begin
                m_req = 1;
                m_tx = m_x + m_ptr * ESP_X + LARG / 2;
                m_ty = m_y + r * ESP_Y + ALT;
                break;
              end
            end
            m_ptr = (m_ptr + 1) % NC;
          end
        end else begin
          m_tcnt++;
        end
      end
    end
  endtask

  // Called at a falling edge with inputs set: predict, queue, advance to the next falling edge.
  task automatic step();
    snap_t s;
    model_step();
    s.x = m_x; s.y = m_y; s.vivos = pack_alive(); s.acerto = m_acerto; s.pontos = m_score;
    s.win = m_win; s.inv = m_inv; s.req = m_req; s.tx = m_tx; s.ty = m_ty;
    exp_q.push_back(s);
    @(negedge CLOCK_50);
  endtask

  always @(posedge CLOCK_50) begin
    snap_t e;
    if (mon_en) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: DUT edge with no expected entry (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("x_base", x_base, e.x);
        check("y_base", y_base, e.y);
        check("vivos", vivos, e.vivos);
        check("acerto", acerto, e.acerto);
        check("pontos", pontos, e.pontos);
        check("todos_mortos", todos_mortos, e.win);
        check("invadiu", invadiu, e.inv);
        check("tiro_req", tiro_req, e.req);
        if (e.req || !SHOT_EN) begin
          check("tiro_x", tiro_x, e.tx);
          check("tiro_y", tiro_y, e.ty);
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, " x_base"}, x_base, XI);
    check({tag, " y_base"}, y_base, YI);
    check({tag, " vivos"}, vivos, 4'b1111);
    check({tag, " pontos"}, pontos, 0);
    check({tag, " acerto"}, acerto, 0);
    check({tag, " todos_mortos"}, todos_mortos, 0);
    check({tag, " invadiu"}, invadiu, 0);
    check({tag, " tiro_req"}, tiro_req, 0);
  endtask

  task automatic restart();
    reiniciarJogo = 1; step(); reiniciarJogo = 0;
  endtask

  task automatic wait_req(input string name, input int budget);
    int n = 0;
    while (tiro_req !== 1'b1 && n < budget) begin step(); n++; end
    check(name, tiro_req, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int xs, tx_exp, ty_exp, n;
    logic [N-1:0] pv;
    bit preq;
    reset = 1; pausa = 0; reiniciarJogo = 0; bola_ativa = 0; tiro_ack = 0; bola_x = 0; bola_y = 0;
    repeat (3) @(negedge CLOCK_50);
    check_reset_values("reset");
    model_reset();
    reset = 0; mon_en = 1;

    // Idle march: four ticks move 4*PX to the right.
    repeat (4 * TD) step();
    check("march after 4 ticks", x_base, 36);

    // Single hit on enemy 0, bullet held afterwards.
    restart();
    bola_x = 25; bola_y = 45; bola_ativa = 1;
    step();
    check("hit acerto", acerto, 1);
    check("hit vivos", vivos, 4'b1110);
    check("hit pontos", pontos, 1);
    repeat (6) begin step(); check("held bullet no repulse", acerto, 0); end
    check("held bullet pontos", pontos, 1);

    // Kill the remaining enemies one per cycle.
    for (int i = 0; i < N; i++) begin
      if (m_alive[i]) begin
        bola_x = 10'(m_x + (i % NC) * ESP_X + LARG / 2);
        bola_y = 10'(m_y + (i / NC) * ESP_Y + ALT / 2);
        step();
        check("kill acerto", acerto, 1);
      end
    end
    bola_ativa = 0;
    check("victory flag", todos_mortos, 1);
    check("victory vivos", vivos, 0);
    xs = m_x;
    repeat (5 * TD) step();
    check("frozen after victory", x_base, xs);
    check("victory held", todos_mortos, 1);

    // Shot handshake.
    restart();
    if (SHOT_EN) begin
      wait_req("shot raised", 10 * TD * TP);
      tx_exp = m_x + LARG / 2;
      ty_exp = m_y + ESP_Y + ALT;
      check("shot x", tiro_x, tx_exp);
      check("shot y", tiro_y, ty_exp);
      repeat (10) begin
        step();
        check("shot held", tiro_req, 1);
        check("shot x stable", tiro_x, tx_exp);
        check("shot y stable", tiro_y, ty_exp);
      end
      tiro_ack = 1; step(); tiro_ack = 0;
      check("shot dropped after ack", tiro_req, 0);
      wait_req("second shot", 10 * TD * TP);
    end else begin
      repeat (6 * TD * TP) step();
      check("shot disabled", tiro_req, 0);
    end

    // Pause freezes everything, with a live bullet and an ack offered.
    pv = pack_alive(); preq = m_req; xs = m_x;
    pausa = 1; tiro_ack = 1; bola_ativa = 1;
    bola_x = 10'(m_x + 5); bola_y = 10'(m_y + 5);
    repeat (50) step();
    check("pause x_base", x_base, xs);
    check("pause vivos", vivos, pv);
    check("pause tiro_req", tiro_req, preq);
    bola_ativa = 0; tiro_ack = 0;
    step();
    pausa = 0;
    restart();
    check_reset_values("restart");

    // Randomised play.
    for (int k = 0; k < 4000; k++) begin
      int bx = m_x - 10 + $urandom_range(0, 100);
      int by = m_y - 10 + $urandom_range(0, 70);
      bola_x = 10'((bx < 0) ? 0 : bx);
      bola_y = 10'((by < 0) ? 0 : by);
      bola_ativa    = ($urandom_range(0, 3) == 0);
      pausa         = ($urandom_range(0, 15) == 0);
      tiro_ack      = ($urandom_range(0, 7) == 0);
      reiniciarJogo = ($urandom_range(0, 199) == 0);
      step();
    end
    pausa = 0; tiro_ack = 0; bola_ativa = 0; reiniciarJogo = 0;

    // Asynchronous reset mid-game, with a shot pending when available.
    restart();
    if (SHOT_EN) wait_req("pending before reset", 10 * TD * TP);
    mon_en = 0;
    reset = 1;
    #1;
    check_reset_values("async reset");
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    exp_q.delete();
    model_reset();
    reset = 0; mon_en = 1;

    // March undisturbed down to the invasion line.
    tiro_ack = 1;
    n = 0;
    while (invadiu !== 1'b1 && n < 40000) begin step(); n++; end
    check("invasion reached", invadiu, 1);
    check("invasion y_base", y_base, 350);
    check("invasion not victory", todos_mortos, 0);
    xs = m_x;
    repeat (5 * TD) step();
    check("frozen after invasion", x_base, xs);
    tiro_ack = 0;

    mon_en = 0;
    @(negedge CLOCK_50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
